euler_step_sequencer: RTL and testbench
=======================================

Name: euler_step_sequencer

Overview:
- Control FSM for one Euler integration run, x[i] += h*f[i] for i = 0..num_vars-1, repeated for num_steps steps.
- Per step: triggers the derivative evaluator, then issues one update request per state variable to the shared Euler update datapath.
- Counts completed steps and signals done.
- Sits between the host/top-level control and the Euler datapath. It is the sequencer for the step counter and update unit.

Parameters:
- STEP_W, 6, width of the step count and num_steps
- VAR_W, 4, width of the variable index and num_vars
- TIMEOUT_W, 8, width of the handshake watchdog counter; limit = 2^TIMEOUT_W - 1 cycles

Ports:
- clk  in  1  system clock, rising edge
- rest_async  in  1  asynchronous reset, active-low
- start  in  1  begin a run; sampled in IDLE only
- abort  in  1  synchronous abort; return to IDLE
- num_steps  in  STEP_W  steps to perform; latched on accepted start
- num_vars  in  VAR_W  state variables per step; latched on accepted start
- eval_start  out  1  one-cycle pulse to the derivative evaluator
- eval_done  in  1  evaluator finished; honoured only in EVAL_WAIT
- upd_req  out  1  update request; level signal, held until acked
- upd_idx  out  VAR_W  variable index for the current update
- upd_ack  in  1  datapath accepted the update at upd_idx
- step_count  out  STEP_W  completed steps in the current or last run
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the run completes
- timeout  out  1  sticky watchdog flag; cleared on the next accepted start

Behaviour:
- Reset (rest_async=0, immediate): state=IDLE; all outputs 0; latched configuration 0; watchdog 0.
- States: IDLE, EVAL_REQ, EVAL_WAIT, UPD, STEP_END, DONE.
- IDLE:
  - start=1 and abort=0 -> latch num_steps/num_vars, clear step_count and timeout.
  - Next state is DONE if num_steps=0, else EVAL_REQ.
- EVAL_REQ: eval_start=1 for exactly this cycle -> EVAL_WAIT.
- EVAL_WAIT:
  - eval_done=1 -> UPD with upd_idx=0 if num_vars!=0; otherwise skip to STEP_END.
  - eval_done is ignored in all other states.
- UPD:
  - upd_req=1 with upd_idx stable until upd_ack.
  - On ack with upd_idx < num_vars-1: upd_idx increments and upd_req stays high (back-to-back updates, 1 per cycle maximum).
  - On ack with upd_idx = num_vars-1: go to STEP_END, upd_req=0 next cycle.
- STEP_END: step_count += 1. If the new value equals num_steps -> DONE, else EVAL_REQ.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- step_count holds its final value in IDLE until the next accepted start. It never wraps, since num_steps <= 2^STEP_W - 1.
- Latency: start sampled at edge 0 -> eval_start in cycle 1. With zero-wait handshakes, one step takes 3 + max(num_vars,0) cycles (EVAL_REQ, EVAL_WAIT, num_vars UPD cycles, STEP_END).
- Watchdog:
  - Counts cycles in EVAL_WAIT and UPD; resets on entry to either state and on every upd_ack.
  - Reaching 2^TIMEOUT_W - 1 without the awaited eval_done/upd_ack -> timeout=1, IDLE next cycle, no done pulse, step_count holds.
- abort=1 in any non-IDLE state:
  - IDLE next cycle; eval_start/upd_req low from that cycle; no done pulse; step_count holds.
  - abort and start in the same cycle in IDLE: abort wins, start ignored.
- start while busy is ignored. num_steps/num_vars changes during a run have no effect.
- Reset asserted mid-run: immediate return to the reset state, including upd_req=0.

Test Plan:
- num_steps=3, num_vars=2, eval_done and upd_ack tied high, start at edge 0 -> eval_start in cycles 1, 6, 11; upd_idx 0,1 in cycles 3-4, 8-9, 13-14; step_count 1,2,3 after cycles 5, 10, 15; done in cycle 16; busy low from cycle 17.
- num_steps=0, num_vars=5, start -> done in cycle 1, no eval_start, no upd_req, step_count=0.
- num_steps=2, num_vars=0 -> no upd_req ever; done in cycle 7; step_count=2.
- TIMEOUT_W=4, num_steps=1, eval_done never asserted -> timeout=1 after 15 cycles in EVAL_WAIT, busy low the next cycle, no done. Next start clears timeout.
- num_steps=4, num_vars=3, abort asserted while upd_idx=1 in step 2 -> upd_req low the next cycle, step_count stays 1, no done. A new start restarts from step_count=0.
- rest_async pulled low mid-UPD (asynchronous to clk) -> upd_req, busy and step_count go to 0 immediately. After release, IDLE holds until start. Also check num_steps=63 runs to step_count=63 without wrap.

Source files
------------

// File: rtl/euler_step_sequencer_if.sv
// Handshake bundle between the Euler step sequencer, its host and the Euler datapath.
// master = host/datapath side, slave = sequencer side.
interface euler_step_sequencer_if #(
  parameter int STEP_W = 6,
  parameter int VAR_W  = 4
);
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] num_steps;
  logic [VAR_W-1:0]  num_vars;
  logic              eval_start;
  logic              eval_done;
  logic              upd_req;
  logic [VAR_W-1:0]  upd_idx;
  logic              upd_ack;
  logic [STEP_W-1:0] step_count;
  logic              busy;
  logic              done;
  logic              timeout;

  modport master (
    output start, abort, num_steps, num_vars, eval_done, upd_ack,
    input  eval_start, upd_req, upd_idx, step_count, busy, done, timeout
  );

  modport slave (
    input  start, abort, num_steps, num_vars, eval_done, upd_ack,
    output eval_start, upd_req, upd_idx, step_count, busy, done, timeout
  );
endinterface

// File: rtl/euler_step_sequencer.sv
// Control FSM for an Euler run: per step, pulse the derivative evaluator, then
// request one datapath update per state variable; counts steps, aborts and times out.
module euler_step_sequencer #(
  parameter int STEP_W    = 6,
  parameter int VAR_W     = 4,
  parameter int TIMEOUT_W = 8
) (
  input logic                   clk,
  input logic                   rest_async,
  euler_step_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL_REQ, S_EVAL_WAIT, S_UPD, S_STEP_END, S_DONE
  } state_t;

  // Counter value on the last permitted waiting cycle (limit - 1).
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                state_q, state_d;
  logic [STEP_W-1:0]     ns_q, ns_d;
  logic [VAR_W-1:0]      nv_q, nv_d;
  logic [STEP_W-1:0]     sc_q, sc_d;
  logic [VAR_W-1:0]      idx_q, idx_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic                  to_q, to_d;
  logic [STEP_W-1:0]     sc_inc;

  assign sc_inc = sc_q + STEP_W'(1);

  always_ff @(posedge clk or negedge rest_async) begin
    if (!rest_async) begin
      state_q <= S_IDLE;
      ns_q    <= '0;
      nv_q    <= '0;
      sc_q    <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ns_q    <= ns_d;
      nv_q    <= nv_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ns_d    = ns_q;
    nv_d    = nv_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    to_d    = to_q;
    // Abort outranks every other event, including a same-cycle timeout.
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            ns_d    = bus.num_steps;
            nv_d    = bus.num_vars;
            sc_d    = '0;
            to_d    = 1'b0;
            state_d = (bus.num_steps == '0) ? S_DONE : S_EVAL_REQ;
          end
        end
        S_EVAL_REQ: begin
          wd_d    = '0;
          state_d = S_EVAL_WAIT;
        end
        S_EVAL_WAIT: begin
          if (bus.eval_done) begin
            if (nv_q != '0) begin
              idx_d   = '0;
              wd_d    = '0;
              state_d = S_UPD;
            end else begin
              state_d = S_STEP_END;
            end
          end else if (wd_q == WD_LAST) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q + TIMEOUT_W'(1);
          end
        end
        S_UPD: begin
          if (bus.upd_ack) begin
            wd_d = '0;
            if (idx_q == nv_q - VAR_W'(1)) begin
              state_d = S_STEP_END;
            end else begin
              idx_d = idx_q + VAR_W'(1);
            end
          end else if (wd_q == WD_LAST) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q + TIMEOUT_W'(1);
          end
        end
        S_STEP_END: begin
          sc_d    = sc_inc;
          state_d = (sc_inc == ns_q) ? S_DONE : S_EVAL_REQ;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.eval_start = (state_q == S_EVAL_REQ);
  assign bus.upd_req    = (state_q == S_UPD);
  assign bus.upd_idx    = idx_q;
  assign bus.step_count = sc_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.timeout    = to_q;

endmodule

// File: tb/tb_euler_step_sequencer.sv
// Scoreboard bench for euler_step_sequencer: each scenario pushes the expected
// per-cycle outputs, and a negedge monitor pops and compares them.
module tb_euler_step_sequencer;

  localparam int STEP_W    = 6;
  localparam int VAR_W     = 4;
  localparam int TIMEOUT_W = 4;

  typedef struct packed {
    logic              es;
    logic              ur;
    logic [VAR_W-1:0]  idx;
    logic [STEP_W-1:0] sc;
    logic              busy;
    logic              done;
    logic              to;
  } rec_t;

  logic  clk = 1'b0;
  logic  rest_async = 1'b0;
  rec_t  exp_q[$];
  int    checks = 0;
  int    fails = 0;
  int    push_budget = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  string tname = "none";

  euler_step_sequencer_if #(.STEP_W(STEP_W), .VAR_W(VAR_W)) bus ();

  euler_step_sequencer #(
    .STEP_W(STEP_W), .VAR_W(VAR_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk),
    .rest_async(rest_async),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Monitor: one expected record per monitored cycle; upd_idx only matters while upd_req.
  always @(negedge clk) begin
    if (mon_en) begin
      rec_t o, e;
      cyc++;
      o.es   = bus.eval_start;
      o.ur   = bus.upd_req;
      o.idx  = bus.upd_req ? bus.upd_idx : '0;
      o.sc   = bus.step_count;
      o.busy = bus.busy;
      o.done = bus.done;
      o.to   = bus.timeout;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s cycle %0d: output seen with empty scoreboard (es=%b ur=%b sc=%0d busy=%b)",
                 tname, cyc, o.es, o.ur, o.sc, o.busy);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s cycle %0d: got es=%b ur=%b idx=%0d sc=%0d busy=%b done=%b to=%b, expected es=%b ur=%b idx=%0d sc=%0d busy=%b done=%b to=%b",
                   tname, cyc, o.es, o.ur, o.idx, o.sc, o.busy, o.done, o.to,
                   e.es, e.ur, e.idx, e.sc, e.busy, e.done, e.to);
        end
      end
    end
  end

  task automatic push_rec(input logic es, input logic ur, input int idx, input int sc,
                          input logic b, input logic d, input logic t);
    rec_t r;
    r.es = es; r.ur = ur; r.idx = VAR_W'(idx); r.sc = STEP_W'(sc);
    r.busy = b; r.done = d; r.to = t;
    if (push_budget > 0) begin
      exp_q.push_back(r);
      push_budget--;
    end
  endtask

  // Zero-wait run: EVAL_REQ, EVAL_WAIT, nv updates, STEP_END per step, then DONE and IDLE.
  task automatic push_run(input int ns, input int nv, input int limit);
    push_budget = limit;
    for (int s = 0; s < ns; s++) begin
      push_rec(1'b1, 1'b0, 0, s, 1'b1, 1'b0, 1'b0);
      push_rec(1'b0, 1'b0, 0, s, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < nv; i++) push_rec(1'b0, 1'b1, i, s, 1'b1, 1'b0, 1'b0);
      push_rec(1'b0, 1'b0, 0, s, 1'b1, 1'b0, 1'b0);
    end
    push_rec(1'b0, 1'b0, 0, ns, 1'b1, 1'b1, 1'b0);
    push_rec(1'b0, 1'b0, 0, ns, 1'b0, 1'b0, 1'b0);
  endtask

  // Returns one time unit after edge 0, i.e. inside cycle 1.
  task automatic do_start(input int ns, input int nv);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_steps = STEP_W'(ns);
    bus.num_vars = VAR_W'(nv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
  endtask

  task automatic watch(input int n);
    mon_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic test_reset;
    tname = "reset";
    #2;
    checks++;
    if ({bus.eval_start, bus.upd_req, bus.busy, bus.done, bus.timeout} !== 5'b0 ||
        bus.step_count !== '0 || bus.upd_idx !== '0) begin
      fails++;
      $display("FAIL reset: got es=%b ur=%b busy=%b done=%b to=%b sc=%0d idx=%0d, expected all 0",
               bus.eval_start, bus.upd_req, bus.busy, bus.done, bus.timeout, bus.step_count, bus.upd_idx);
    end
    @(posedge clk); #1;
    rest_async = 1'b1;
    $display("run reset: outputs checked while held in reset");
  endtask

  task automatic test_basic;
    tname = "basic";
    exp_q.delete();
    push_run(3, 2, 1000);
    do_start(3, 2);
    watch(17);
    $display("run basic ns=3 nv=2: %0d cycles checked", cyc);
  endtask

  task automatic test_zero_steps;
    tname = "zero_steps";
    exp_q.delete();
    push_run(0, 5, 1000);
    do_start(0, 5);
    watch(2);
    $display("run zero_steps ns=0 nv=5: %0d cycles checked", cyc);
  endtask

  // Also holds start high and changes the configuration mid-run; both must be ignored.
  task automatic test_zero_vars;
    tname = "zero_vars";
    exp_q.delete();
    push_run(2, 0, 1000);
    do_start(2, 0);
    mon_en = 1'b1;
    bus.start = 1'b1;
    bus.num_steps = 6'd9;
    bus.num_vars = 4'd3;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("run zero_vars ns=2 nv=0: %0d cycles checked", cyc);
  endtask

  task automatic test_timeout;
    tname = "timeout";
    exp_q.delete();
    bus.eval_done = 1'b0;
    push_budget = 1000;
    push_rec(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) push_rec(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_rec(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    do_start(1, 2);
    watch(19);
    bus.eval_done = 1'b1;
    $display("run timeout ns=1 eval_done stuck low: %0d cycles checked", cyc);
    tname = "timeout_clear";
    push_run(0, 0, 1000);
    do_start(0, 0);
    watch(2);
    $display("run timeout_clear: %0d cycles checked", cyc);
  endtask

  task automatic test_abort;
    tname = "abort";
    exp_q.delete();
    push_run(4, 3, 10);
    push_budget = 3;
    for (int i = 0; i < 3; i++) push_rec(1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
    do_start(4, 3);
    watch(9);
    bus.abort = 1'b1;
    watch(1);
    bus.abort = 1'b0;
    watch(3);
    $display("run abort ns=4 nv=3 at step 2 idx 1: %0d cycles checked", cyc);
    tname = "abort_restart";
    push_run(1, 1, 1000);
    do_start(1, 1);
    watch(6);
    $display("run abort_restart ns=1 nv=1: %0d cycles checked", cyc);
  endtask

  task automatic test_async_reset;
    tname = "async_reset";
    exp_q.delete();
    push_run(3, 2, 7);
    do_start(3, 2);
    watch(7);
    #2;
    checks++;
    if (bus.upd_req !== 1'b1 || bus.step_count !== 6'd1) begin
      fails++;
      $display("FAIL async_reset pre: got ur=%b sc=%0d, expected ur=1 sc=1", bus.upd_req, bus.step_count);
    end
    rest_async = 1'b0;
    #1;
    checks++;
    if (bus.upd_req !== 1'b0 || bus.busy !== 1'b0 || bus.step_count !== '0 ||
        bus.eval_start !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got ur=%b busy=%b sc=%0d es=%b done=%b, expected all 0",
               bus.upd_req, bus.busy, bus.step_count, bus.eval_start, bus.done);
    end
    @(posedge clk); #1;
    rest_async = 1'b1;
    push_budget = 4;
    for (int i = 0; i < 4; i++) push_rec(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    watch(4);
    $display("run async_reset mid-UPD: %0d cycles checked", cyc);
  endtask

  task automatic test_max_steps;
    tname = "max_steps";
    exp_q.delete();
    push_run(63, 1, 1000);
    do_start(63, 1);
    watch(63 * 4 + 2);
    $display("run max_steps ns=63 nv=1: %0d cycles checked", cyc);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_steps = '0;
    bus.num_vars = '0;
    bus.eval_done = 1'b1;
    bus.upd_ack = 1'b1;
    test_reset();
    test_basic();
    test_zero_steps();
    test_zero_vars();
    test_timeout();
    test_abort();
    test_async_reset();
    test_max_steps();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
